// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and status-flag bit positions for the pipelined ALU.
package alu_pipe_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_pipe_core.sv
// Purely combinational op/flag compute for alu_pipe, kept separate for timing characterisation.
// Optional: define ALU_PIPE_SAT_EN to saturate ADD/SUB on signed overflow instead of wrapping.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          diff;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic [SH_W-1:0]         shamt;
  logic                    add_ovf;
  logic                    sub_ovf;
  logic                    carry;
  logic                    ovf;

  // Overflow direction follows the sign of operand a for both ADD and SUB.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic             of,
                                                input logic             neg);
    if (!of)
      return raw;
    else if (neg)
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign sa    = a;
  assign sb    = b;
  assign shamt = b[SH_W-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        carry = sum[WIDTH];
        ovf   = add_ovf;
`ifdef ALU_PIPE_SAT_EN
        y     = saturate(sum[WIDTH-1:0], add_ovf, a[WIDTH-1]);
`else
        y     = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        carry = diff[WIDTH];
        ovf   = sub_ovf;
`ifdef ALU_PIPE_SAT_EN
        y     = saturate(diff[WIDTH-1:0], sub_ovf, a[WIDTH-1]);
`else
        y     = diff[WIDTH-1:0];
`endif
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << shamt;
      OP_SHR:  y = a >> shamt;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, (sa < sb)};
      default: y = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = y[WIDTH-1];
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined 8-op ALU with N/Z/C/V flags, valid/ready on both sides and a hand-off counter.
// Optional: ALU_PIPE_SAT_EN (handled in alu_pipe_core) selects saturating ADD/SUB.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] op_count
);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("alu_pipe: WIDTH must be a power of two in 4..64");
  end

  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [2:0]       op_p1;
  logic             vld_p1;

  logic [WIDTH-1:0] y_p2;
  logic [3:0]       flags_p2;
  logic             vld_p2;

  logic [WIDTH-1:0] y_c;
  logic [3:0]       flags_c;

  logic s2_free;
  logic advance;
  logic accept;
  logic handoff;

  // No skid buffer: in_ready looks straight through to out_ready.
  assign s2_free  = ~vld_p2 | out_ready;
  assign advance  = vld_p1 & s2_free;
  assign in_ready = ~vld_p1 | s2_free;
  assign accept   = in_valid & in_ready;
  assign handoff  = vld_p2 & out_ready;

  // ---- stage 1: input register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (accept)
      vld_p1 <= 1'b1;
    else if (advance)
      vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1  <= in_a;
      b_p1  <= in_b;
      op_p1 <= in_op;
    end
  end

  alu_pipe_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a     (a_p1),
    .b     (b_p1),
    .op    (op_p1),
    .y     (y_c),
    .flags (flags_c)
  );

  // ---- stage 2: output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      y_p2     <= '0;
      flags_p2 <= '0;
    end else begin
      if (advance) begin
        vld_p2   <= 1'b1;
        y_p2     <= y_c;
        flags_p2 <= flags_c;
      end else if (out_ready) begin
        vld_p2   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_count <= '0;
    else if (handoff)
      op_count <= op_count + 1'b1;
  end

  assign out_valid = vld_p2;
  assign out_y     = y_p2;
  assign out_flags = flags_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with a scoreboard model checked on every falling edge.
module tb_alu_pipe;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_y;
  logic [3:0]    out_flags;
  logic [CW-1:0] op_count;

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_q[$];
  int          mcount = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] y_prev;
  logic [3:0]  f_prev;

  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_flags (out_flags),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference behaviour from plain integer arithmetic; returns {y, N, Z, C, V}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    int ua, ub, sa, sb, t, r;
    logic [15:0] y;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    y = '0; c = 1'b0; v = 1'b0; t = 0; r = 0;
    case (op)
      3'd0: begin
        r = ua + ub; t = sa + sb;
        y = r[15:0]; c = (r > 65535); v = (t > 32767) || (t < -32768);
      end
      3'd1: begin
        r = ua - ub; t = sa - sb;
        y = r[15:0]; c = (ua >= ub); v = (t > 32767) || (t < -32768);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << b[3:0];
      3'd6: y = a >> b[3:0];
      default: y = (sa < sb) ? 16'd1 : 16'd0;
    endcase
`ifdef ALU_PIPE_SAT_EN
    if (op <= 3'd1 && v) y = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {y, y[15], (y == 16'd0), c, v};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mcount = 0;
      stall_prev = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
    end else begin
      check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
      check("op_count", 32'(op_count), 32'(mcount % (1 << CW)));
      if (stall_prev) begin
        check("stall_y", 32'(out_y), 32'(y_prev));
        check("stall_flags", 32'(out_flags), 32'(f_prev));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("model_y", 32'(out_y), 32'(exp_q[0][19:4]));
          check("model_flags", 32'(out_flags), 32'(exp_q[0][3:0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            mcount++;
          end
        end
      end
      stall_prev = out_valid & ~out_ready;
      y_prev = out_y;
      f_prev = out_flags;
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op));
    end
  end

  // Called just after a rising edge with an empty pipeline and out_ready=1.
  task automatic run_one(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic [15:0] ey, input logic [3:0] ef);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_y"}, 32'(out_y), 32'(ey));
    check({name, "_flags"}, 32'(out_flags), 32'(ef));
    @(posedge clk); #2;
  endtask

  int sent;
  int got;
  int seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_y", 32'(out_y), 32'd0);
    check("reset_out_flags", 32'(out_flags), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;

    run_one("add", 16'd15, 16'd4, 3'd0, 16'd19, 4'b0000);
    check("count_after_add", 32'(op_count), 32'd1);
    run_one("sub_pos", 16'd15, 16'd4, 3'd1, 16'd11, 4'b0010);
    run_one("sub_neg", 16'd4, 16'd15, 3'd1, 16'hFFF5, 4'b1000);
`ifdef ALU_PIPE_SAT_EN
    run_one("add_ovf", 16'h7FFF, 16'h0001, 3'd0, 16'h7FFF, 4'b0001);
    run_one("sub_ovf", 16'h8000, 16'h0001, 3'd1, 16'h8000, 4'b1011);
`else
    run_one("add_ovf", 16'h7FFF, 16'h0001, 3'd0, 16'h8000, 4'b1001);
    run_one("sub_ovf", 16'h8000, 16'h0001, 3'd1, 16'h7FFF, 4'b0011);
`endif
    run_one("and", 16'h0F0F, 16'h00FF, 3'd2, 16'h000F, 4'b0000);
    run_one("or", 16'h00F0, 16'h0F00, 3'd3, 16'h0FF0, 4'b0000);
    run_one("xor", 16'hFFFF, 16'hFFFF, 3'd4, 16'h0000, 4'b0100);
    run_one("shl", 16'h0001, 16'd15, 3'd5, 16'h8000, 4'b1000);
    run_one("shr", 16'h8000, 16'h002F, 3'd6, 16'h0001, 4'b0000);
    run_one("slt", 16'hFFFF, 16'h0001, 3'd7, 16'h0001, 4'b0000);
    run_one("slt_false", 16'h0001, 16'hFFFF, 3'd7, 16'h0000, 4'b0100);

    // Backpressure: four back-to-back ADDs against a stalled sink.
    out_ready = 1'b0;
    sent = 0;
    got = 0;
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          int w;
          in_a = 16'(i); in_b = 16'(i); in_op = 3'd0; in_valid = 1'b1;
          w = 0;
          while (w < 60) begin
            @(negedge clk);
            if (in_ready) break;
            w++;
          end
          if (w >= 60) check("bp_send_timeout", 32'(w), 32'd0);
          sent++;
          @(posedge clk); #2;
        end
        in_valid = 1'b0;
      end
      begin
        int w;
        repeat (6) @(negedge clk);
        check("bp_accepted", 32'(sent), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold_y", 32'(out_y), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        w = 0;
        while (got < 4 && w < 60) begin
          @(negedge clk);
          w++;
          if (out_valid) begin
            check("bp_order", 32'(out_y), 32'(2 * (got + 1)));
            got++;
          end
        end
        check("bp_results", 32'(got), 32'd4);
      end
    join
    @(posedge clk); #2;

    // Reset with two ops in flight.
    in_a = 16'd5; in_b = 16'd5; in_op = 3'd0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_a = 16'd6; in_b = 16'd6;
    @(posedge clk); #2;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale", 32'(seen), 32'd0);
    @(posedge clk); #2;

    // Counter wrap: 17 completions on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      in_a = 16'(i); in_b = 16'd1; in_op = 3'd0; in_valid = 1'b1;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wrap_count", 32'(op_count), 32'd1);

    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
